if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipelined processor. Consumes the current PC from the program-counter register and reads the instruction memory. Computes the next PC and its write enable for that register, and holds the IF/ID pipeline register that feeds decode. Also owns the run-control FSM (idle / run / halted) and the debug loader port that writes the instruction memory before execution.

---
 rtl/if_stage_pkg.sv | 8 +
 rtl/if_stage_if.sv | 30 +++
 rtl/if_stage_instr_mem.sv | 16 +
 rtl/if_stage.sv | 52 +++++
 tb/tb_if_stage.sv | 106 ++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared widths, special instruction encodings and run-control states
package if_stage_pkg;
  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 8;
  localparam logic [NB_DATA-1:0] NOP_INSTR = '0;
  localparam logic [NB_DATA-1:0] HALT_INSTR = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2} state_e;
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: PC-register, control, loader and IF/ID signals of the fetch stage
interface if_stage_if
  import if_stage_pkg::*;
();
  logic [NB_DATA-1:0] i_pc;
  logic [NB_DATA-1:0] o_next_pc;
  logic o_pc_write;
  logic i_start;
  logic i_enable;
  logic i_stall;
  logic i_jump_taken;
  logic [NB_DATA-1:0] i_jump_target;
  logic i_load_we;
  logic [NB_ADDR-1:0] i_load_addr;
  logic [NB_DATA-1:0] i_load_data;
  logic [NB_DATA-1:0] o_instr;
  logic [NB_DATA-1:0] o_pc_plus4;
  logic o_valid;
  logic o_halted;
  modport master (
    output i_pc, i_start, i_enable, i_stall, i_jump_taken, i_jump_target,
           i_load_we, i_load_addr, i_load_data,
    input  o_next_pc, o_pc_write, o_instr, o_pc_plus4, o_valid, o_halted
  );
  modport slave (
    input  i_pc, i_start, i_enable, i_stall, i_jump_taken, i_jump_target,
           i_load_we, i_load_addr, i_load_data,
    output o_next_pc, o_pc_write, o_instr, o_pc_plus4, o_valid, o_halted
  );
endinterface

// File: rtl/if_stage_instr_mem.sv
// instr_mem: instruction memory, synchronous write, combinational read, no reset
module instr_mem
  import if_stage_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [NB_ADDR-1:0] i_waddr,
  input  logic [NB_DATA-1:0] i_wdata,
  input  logic [NB_ADDR-1:0] i_raddr,
  output logic [NB_DATA-1:0] o_rdata
);
  logic [NB_DATA-1:0] mem_q [2**NB_ADDR];
  always_ff @(posedge i_clk)
    if (i_we) mem_q[i_waddr] <= i_wdata;
  assign o_rdata = mem_q[i_raddr];
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch with next-PC logic, IF/ID register and run-control FSM
module if_stage
  import if_stage_pkg::*;
(
  input logic       i_clk,
  input logic       i_reset,
  if_stage_if.slave bus
);
  state_e state_q, state_d;
  logic [NB_DATA-1:0] instr_q, instr_d, pc4_q, pc4_d, fetched, pc_plus4;
  logic valid_q, valid_d, advance, is_halt, running, capture, bubble;
  instr_mem u_mem (
    .i_clk   (i_clk),
    .i_we    (bus.i_load_we & ~running),
    .i_waddr (bus.i_load_addr),
    .i_wdata (bus.i_load_data),
    .i_raddr (bus.i_pc[NB_ADDR+1:2]),
    .o_rdata (fetched)
  );
  assign running  = state_q == RUN;
  assign pc_plus4 = bus.i_pc + NB_DATA'(4);
  assign is_halt  = fetched == HALT_INSTR;
  assign advance  = running & bus.i_enable & ~bus.i_stall;
  assign bus.o_next_pc  = bus.i_jump_taken ? bus.i_jump_target : pc_plus4;
  assign bus.o_pc_write = advance & ~(is_halt & ~bus.i_jump_taken);
  // outside RUN the IF/ID register is flushed every cycle
  assign capture = ~running | advance;
  assign bubble  = ~running | bus.i_jump_taken;
  always_comb begin
    instr_d = !capture ? instr_q : bubble ? NOP_INSTR : fetched;
    pc4_d   = !capture ? pc4_q   : bubble ? '0 : pc_plus4;
    valid_d = !capture ? valid_q : ~bubble;
    state_d = (state_q == IDLE && bus.i_start) ? RUN :
              (running && advance && !bus.i_jump_taken && is_halt) ? HALTED : state_q;
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state_q <= IDLE;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  assign bus.o_instr    = instr_q;
  assign bus.o_pc_plus4 = pc4_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_halted   = state_q == HALTED;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed vectors with a scoreboard queue checked by a negedge monitor
module tb_if_stage;
  import if_stage_pkg::*;
  typedef struct {
    string       name;
    logic [31:0] npc;
    logic        pcw;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  if_stage_if bus();
  if_stage dut (.i_clk(clk), .i_reset(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %h, expected %h", n, f, act, req);
    end
  endtask
  // monitor: each cycle's entry describes what should be visible mid-cycle
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "next_pc", bus.o_next_pc, e.npc);
      chk(e.name, "pc_write", {31'd0, bus.o_pc_write}, {31'd0, e.pcw});
      chk(e.name, "instr", bus.o_instr, e.instr);
      chk(e.name, "pc_plus4", bus.o_pc_plus4, e.pc4);
      chk(e.name, "valid", {31'd0, bus.o_valid}, {31'd0, e.valid});
      chk(e.name, "halted", {31'd0, bus.o_halted}, {31'd0, e.halted});
    end
  task automatic cyc(input string n, input logic r, st, en, stl, jmp, input logic [31:0] tgt, pc,
                     input logic lwe, input logic [7:0] la, input logic [31:0] ld,
                     input logic [31:0] npc, input logic pcw, input logic [31:0] ins, p4,
                     input logic v, h);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    bus.i_start = st;
    bus.i_enable = en;
    bus.i_stall = stl;
    bus.i_jump_taken = jmp;
    bus.i_jump_target = tgt;
    bus.i_pc = pc;
    bus.i_load_we = lwe;
    bus.i_load_addr = la;
    bus.i_load_data = ld;
    e.name = n; e.npc = npc; e.pcw = pcw; e.instr = ins; e.pc4 = p4; e.valid = v; e.halted = h;
    q.push_back(e);
  endtask
  initial begin
    bus.i_pc = '0; bus.i_start = 0; bus.i_enable = 0; bus.i_stall = 0; bus.i_jump_taken = 0;
    bus.i_jump_target = '0; bus.i_load_we = 0; bus.i_load_addr = '0; bus.i_load_data = '0;
    repeat (2) @(posedge clk);
    //   name        rst st en sl jp tgt    pc     lwe la  ldata         npc   pcw instr         pc4   v  h
    cyc("reset",     0, 0, 0, 0, 0, 0,     0,     0,  0,  0,            4,    0,  0,            0,    0, 0);
    cyc("load0",     0, 0, 0, 0, 0, 0,     0,     1,  0,  32'h11,       4,    0,  0,            0,    0, 0);
    cyc("load1",     0, 0, 0, 0, 0, 0,     0,     1,  1,  32'h22,       4,    0,  0,            0,    0, 0);
    cyc("load2",     0, 0, 0, 0, 0, 0,     0,     1,  2,  32'h33,       4,    0,  0,            0,    0, 0);
    cyc("load3",     0, 0, 0, 0, 0, 0,     0,     1,  3,  32'h44,       4,    0,  0,            0,    0, 0);
    cyc("load5",     0, 0, 0, 0, 0, 0,     0,     1,  5,  HALT_INSTR,   4,    0,  0,            0,    0, 0);
    cyc("load6",     0, 0, 0, 0, 0, 0,     0,     1,  6,  32'h66,       4,    0,  0,            0,    0, 0);
    cyc("load16",    0, 0, 0, 0, 0, 0,     0,     1,  16, 32'h1616,     4,    0,  0,            0,    0, 0);
    cyc("start",     0, 1, 1, 0, 0, 0,     0,     0,  0,  0,            4,    0,  0,            0,    0, 0);
    cyc("fetch0",    0, 0, 1, 0, 0, 0,     0,     0,  0,  0,            4,    1,  0,            0,    0, 0);
    cyc("fetch4",    0, 0, 1, 0, 0, 0,     4,     0,  0,  0,            8,    1,  32'h11,       4,    1, 0);
    cyc("stall1",    0, 0, 1, 1, 0, 0,     8,     0,  0,  0,            12,   0,  32'h22,       8,    1, 0);
    cyc("stall2",    0, 0, 1, 1, 0, 0,     8,     0,  0,  0,            12,   0,  32'h22,       8,    1, 0);
    cyc("resume",    0, 0, 1, 0, 0, 0,     8,     0,  0,  0,            12,   1,  32'h22,       8,    1, 0);
    cyc("jump",      0, 0, 1, 0, 1, 32'h40,32'hC, 0,  0,  0,            32'h40,1, 32'h33,       12,   1, 0);
    cyc("tgt40",     0, 0, 1, 0, 0, 0,     32'h40,0,  0,  0,            32'h44,1, 0,            0,    0, 0);
    cyc("stalljmp",  0, 0, 1, 1, 1, 32'h80,32'h44,0,  0,  0,            32'h80,0, 32'h1616,     32'h44,1,0);
    cyc("jmphalt",   0, 0, 1, 0, 1, 32'h18,32'h14,0,  0,  0,            32'h18,1, 32'h1616,     32'h44,1,0);
    cyc("runload",   0, 0, 1, 0, 0, 0,     32'h18,1,  3,  32'hDEAD,     32'h1C,1, 0,            0,    0, 0);
    cyc("freeze",    0, 0, 0, 0, 0, 0,     32'hC, 0,  0,  0,            32'h10,0, 32'h66,       32'h1C,1,0);
    cyc("fetchC",    0, 0, 1, 0, 0, 0,     32'hC, 0,  0,  0,            32'h10,1, 32'h66,       32'h1C,1,0);
    cyc("halt",      0, 0, 1, 0, 0, 0,     32'h14,0,  0,  0,            32'h18,0, 32'h44,       32'h10,1,0);
    cyc("halted",    0, 1, 1, 0, 0, 0,     32'h18,1,  0,  32'hAA,       32'h1C,0, HALT_INSTR,   32'h18,1,1);
    cyc("hbubble",   0, 0, 1, 0, 0, 0,     32'h18,0,  0,  0,            32'h1C,0, 0,            0,    0, 1);
    cyc("rsthalt",   1, 0, 1, 0, 0, 0,     32'h18,0,  0,  0,            32'h1C,0, 0,            0,    0, 0);
    cyc("restart",   0, 1, 1, 0, 0, 0,     0,     0,  0,  0,            4,    0,  0,            0,    0, 0);
    cyc("rfetch0",   0, 0, 1, 0, 0, 0,     0,     0,  0,  0,            4,    1,  0,            0,    0, 0);
    cyc("rfetch4",   0, 0, 1, 0, 0, 0,     4,     0,  0,  0,            8,    1,  32'hAA,       4,    1, 0);
    cyc("rstmid",    1, 0, 1, 0, 0, 0,     8,     0,  0,  0,            12,   0,  0,            0,    0, 0);
    cyc("restart2",  0, 1, 1, 0, 0, 0,     0,     0,  0,  0,            4,    0,  0,            0,    0, 0);
    cyc("r2fetch0",  0, 0, 1, 0, 0, 0,     0,     0,  0,  0,            4,    1,  0,            0,    0, 0);
    cyc("r2hold",    0, 0, 0, 0, 0, 0,     4,     0,  0,  0,            8,    0,  32'hAA,       4,    1, 0);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
